// File: rtl/mem_ctrl_if.sv
// Request/response channel between one cache and the main-memory controller.
// The cache drives the master side; the controller drives the slave side.
interface mem_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 64
);
    typedef logic              req_type_t;
    typedef logic [ADDR_W-1:0] main_mem_block_addr_t;
    typedef logic [DATA_W-1:0] block_data_t;

    logic                 req_valid;
    req_type_t            req_type;
    main_mem_block_addr_t req_block_addr;
    block_data_t          req_block_data;
    logic                 req_ready;
    logic                 resp_valid;
    block_data_t          resp_block_data;

    modport master (
        output req_valid,
        output req_type,
        output req_block_addr,
        output req_block_data,
        input  req_ready,
        input  resp_valid,
        input  resp_block_data
    );

    modport slave (
        input  req_valid,
        input  req_type,
        input  req_block_addr,
        input  req_block_data,
        output req_ready,
        output resp_valid,
        output resp_block_data
    );
endinterface

// File: rtl/mem_ctrl.sv
// Main-memory controller for icache/dcache: one block request in flight, fixed-latency array.
// MEM_CTRL_ICACHE_PRIO_EN selects fixed icache priority; default build is round-robin.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | no request in flight; readiness follows the arbitration rule
// ST_BUSY | request in flight; counter runs down to 0, reads respond at 0
module mem_ctrl #(
    parameter int MEM_LATENCY = 10,
    parameter int N_BLOCKS    = 1024,
    parameter int VERBOSE     = 0,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 64
) (
    input  logic      clk,
    input  logic      rst_aL,
    mem_ctrl_if.slave icache,
    mem_ctrl_if.slave dcache
);

    localparam int IDX_W = $clog2(N_BLOCKS);
    localparam int CNT_W = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    localparam logic REQ_WRITE = 1'b1;
    localparam logic ID_ICACHE = 1'b0;
    localparam logic ID_DCACHE = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              id_q, id_d;
    logic              type_q, type_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    logic [DATA_W-1:0] mem [N_BLOCKS];

    logic              is_idle;
    logic              ic_ready;
    logic              dc_ready;
    logic              ic_acc;
    logic              dc_acc;
    logic              accept;
    logic              acc_id;
    logic              acc_type;
    logic [IDX_W-1:0]  acc_idx;
    logic [DATA_W-1:0] acc_data;

    logic              resp_fire;
    logic              ic_fire;
    logic              dc_fire;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] ic_hold_q;
    logic [DATA_W-1:0] dc_hold_q;

    assign is_idle = (state_q == ST_IDLE);

`ifdef MEM_CTRL_ICACHE_PRIO_EN
    assign ic_ready = is_idle;
    assign dc_ready = is_idle && !icache.req_valid;
`else
    logic last_grant_q;

    // On a tie the requester that was not granted last time wins.
    assign ic_ready = is_idle && (!dcache.req_valid || (last_grant_q == ID_DCACHE));
    assign dc_ready = is_idle && (!icache.req_valid || (last_grant_q == ID_ICACHE));

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            last_grant_q <= ID_ICACHE;
        end else if (accept) begin
            last_grant_q <= acc_id;
        end
    end
`endif

    assign icache.req_ready = ic_ready;
    assign dcache.req_ready = dc_ready;

    assign ic_acc   = icache.req_valid && ic_ready;
    assign dc_acc   = dcache.req_valid && dc_ready;
    assign accept   = ic_acc || dc_acc;
    assign acc_id   = dc_acc ? ID_DCACHE : ID_ICACHE;
    assign acc_type = dc_acc ? dcache.req_type : icache.req_type;
    assign acc_idx  = dc_acc ? dcache.req_block_addr[IDX_W-1:0]
                             : icache.req_block_addr[IDX_W-1:0];
    assign acc_data = dc_acc ? dcache.req_block_data : icache.req_block_data;

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            id_q    <= 1'b0;
            type_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            type_q  <= type_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        type_d  = type_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_BUSY;
                    cnt_d   = CNT_LOAD;
                    id_d    = acc_id;
                    type_d  = acc_type;
                    idx_d   = acc_idx;
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Writes commit at the accept edge, so a later read always sees them.
    always_ff @(posedge clk) begin
        if (accept && (acc_type == REQ_WRITE)) begin
            mem[acc_idx] <= acc_data;
        end
    end

    assign resp_fire = (state_q == ST_BUSY) && (cnt_q == '0) && (type_q != REQ_WRITE);
    assign ic_fire   = resp_fire && (id_q == ID_ICACHE);
    assign dc_fire   = resp_fire && (id_q == ID_DCACHE);
    assign rd_data   = mem[idx_q];

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            ic_hold_q <= '0;
            dc_hold_q <= '0;
        end else begin
            if (ic_fire) begin
                ic_hold_q <= rd_data;
            end
            if (dc_fire) begin
                dc_hold_q <= rd_data;
            end
        end
    end

    assign icache.resp_valid      = ic_fire;
    assign dcache.resp_valid      = dc_fire;
    assign icache.resp_block_data = ic_fire ? rd_data : ic_hold_q;
    assign dcache.resp_block_data = dc_fire ? rd_data : dc_hold_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: readiness table, transaction table with a response scoreboard,
// tie arbitration, reset mid-BUSY, and a MEM_LATENCY=1 instance.
module tb_mem_ctrl;

    localparam int LAT = 10;
    localparam int NB  = 1024;
    localparam int NB1 = 16;

    typedef logic [15:0] addr_t;
    typedef logic [63:0] data_t;

    typedef struct { data_t data; int due; } exp_t;
    typedef struct { bit ic_v; bit dc_v; bit ic_rdy; bit dc_rdy; } rdy_vec_t;
    typedef struct { bit port; bit wr; addr_t addr; data_t data; } txn_t;

    logic clk = 1'b0;
    logic rst_aL = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    exp_t  ic_q[$];
    exp_t  dc_q[$];
    bit    grant_log[$];
    int    acc_cyc[$];
    data_t model [int];
    bit    ic_took = 1'b0;
    bit    dc_took = 1'b0;

    mem_ctrl_if ic ();
    mem_ctrl_if dc ();
    mem_ctrl_if ic1 ();
    mem_ctrl_if dc1 ();

    mem_ctrl #(.MEM_LATENCY(LAT), .N_BLOCKS(NB)) dut (
        .clk    (clk),
        .rst_aL (rst_aL),
        .icache (ic),
        .dcache (dc)
    );

    mem_ctrl #(.MEM_LATENCY(1), .N_BLOCKS(NB1)) dut1 (
        .clk    (clk),
        .rst_aL (rst_aL),
        .icache (ic1),
        .dcache (dc1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic note_accept(input bit port, input bit wr, input addr_t a, input data_t d);
        int   idx;
        exp_t e;
        idx = int'(a) % NB;
        grant_log.push_back(port);
        acc_cyc.push_back(cyc);
        if (wr) begin
            model[idx] = d;
        end else begin
            e.data = model.exists(idx) ? model[idx] : '0;
            e.due  = cyc + LAT;
            if (port) dc_q.push_back(e);
            else      ic_q.push_back(e);
        end
    endtask

    task automatic check_resp(input bit port, input data_t d);
        exp_t e;
        if (port ? (dc_q.size() == 0) : (ic_q.size() == 0)) begin
            fail(port ? "dc_unexpected_resp" : "ic_unexpected_resp");
        end else begin
            e = port ? dc_q.pop_front() : ic_q.pop_front();
            chk(port ? "dc_resp_data"  : "ic_resp_data",  d, e.data);
            chk(port ? "dc_resp_cycle" : "ic_resp_cycle", 64'(cyc), 64'(e.due));
        end
    endtask

    // Accept recorder and response scoreboard for the main instance.
    always @(negedge clk) begin
        if (rst_aL) begin
            if (ic.req_valid && ic.req_ready && dc.req_valid && dc.req_ready)
                fail("double_grant");
            if (ic.req_valid && ic.req_ready) begin
                note_accept(1'b0, ic.req_type, ic.req_block_addr, ic.req_block_data);
                ic_took = 1'b1;
            end
            if (dc.req_valid && dc.req_ready) begin
                note_accept(1'b1, dc.req_type, dc.req_block_addr, dc.req_block_data);
                dc_took = 1'b1;
            end
            if (ic.resp_valid) check_resp(1'b0, ic.resp_block_data);
            if (dc.resp_valid) check_resp(1'b1, dc.resp_block_data);
            if (ic_q.size() > 0 && ic_q[0].due < cyc) begin
                fail("ic_resp_missing");
                void'(ic_q.pop_front());
            end
            if (dc_q.size() > 0 && dc_q[0].due < cyc) begin
                fail("dc_resp_missing");
                void'(dc_q.pop_front());
            end
        end
    end

    task automatic set_req(input bit port, input bit v, input bit wr, input addr_t a, input data_t d);
        if (port) begin
            dc.req_valid = v; dc.req_type = wr; dc.req_block_addr = a; dc.req_block_data = d;
        end else begin
            ic.req_valid = v; ic.req_type = wr; ic.req_block_addr = a; ic.req_block_data = d;
        end
    endtask

    task automatic wait_took(input bit want_ic, input bit want_dc);
        int n = 0;
        bit need_i = want_ic;
        bit need_d = want_dc;
        while ((need_i || need_d) && n < 400) begin
            @(posedge clk); #1;
            n++;
            if (need_i && ic_took) begin ic_took = 1'b0; need_i = 1'b0; ic.req_valid = 1'b0; end
            if (need_d && dc_took) begin dc_took = 1'b0; need_d = 1'b0; dc.req_valid = 1'b0; end
        end
        if (need_i || need_d) begin
            fail("accept_timeout");
            ic.req_valid = 1'b0;
            dc.req_valid = 1'b0;
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_drained(input string name);
        chk({name, "_ic_pending"}, 64'(ic_q.size()), 64'd0);
        chk({name, "_dc_pending"}, 64'(dc_q.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rdy_vec_t rv[4];
        txn_t     tv[8];
        data_t    a_dat = 64'hA5A5_0000_1111_2222;
        data_t    b_dat = 64'h0BB0_3333_4444_5555;
        data_t    c_dat = 64'hC0C0_6666_7777_8888;
        data_t    d_dat = 64'hDDDD_9999_AAAA_BBBB;
        data_t    e_dat = 64'hEEEE_1234_5678_9ABC;

`ifdef MEM_CTRL_ICACHE_PRIO_EN
        rv[0] = '{0, 0, 1, 1};
        rv[1] = '{1, 0, 1, 0};
        rv[2] = '{0, 1, 1, 1};
        rv[3] = '{1, 1, 1, 0};
`else
        rv[0] = '{0, 0, 1, 1};
        rv[1] = '{1, 0, 1, 1};
        rv[2] = '{0, 1, 0, 1};
        rv[3] = '{1, 1, 0, 1};
`endif
        tv[0] = '{1, 1, 16'd5,         a_dat};
        tv[1] = '{1, 0, 16'd5,         '0};
        tv[2] = '{0, 1, 16'(NB + 3),   b_dat};
        tv[3] = '{1, 0, 16'd3,         '0};
        tv[4] = '{0, 0, 16'd5,         '0};
        tv[5] = '{1, 1, 16'd7,         c_dat};
        tv[6] = '{0, 0, 16'd7,         '0};
        tv[7] = '{1, 0, 16'(NB + 3),   '0};

        set_req(0, 0, 0, '0, '0);
        set_req(1, 0, 0, '0, '0);
        ic1.req_valid = 0; ic1.req_type = 0; ic1.req_block_addr = '0; ic1.req_block_data = '0;
        dc1.req_valid = 0; dc1.req_type = 0; dc1.req_block_addr = '0; dc1.req_block_data = '0;

        rst_aL = 1'b0;
        wait_cycles(3);
        chk("rst_ic_resp_valid", ic.resp_valid, 0);
        chk("rst_dc_resp_valid", dc.resp_valid, 0);
        rst_aL = 1'b1;
        #1;
        chk("rst_ic1_ready", ic1.req_ready, 1);
        chk("rst_dc1_ready", dc1.req_ready, 1);

        // Readiness in IDLE, applied and withdrawn within one cycle so nothing is accepted.
        for (int i = 0; i < 4; i++) begin
            ic.req_valid = rv[i].ic_v;
            dc.req_valid = rv[i].dc_v;
            #2;
            chk($sformatf("rdy_tbl%0d_ic", i), ic.req_ready, rv[i].ic_rdy);
            chk($sformatf("rdy_tbl%0d_dc", i), dc.req_ready, rv[i].dc_rdy);
            ic.req_valid = 1'b0;
            dc.req_valid = 1'b0;
            wait_cycles(1);
        end
        chk("rdy_tbl_no_accept", 64'(grant_log.size()), 64'd0);

        // Sequential transactions; the scoreboard checks data, latency and routing.
        for (int i = 0; i < 8; i++) begin
            set_req(tv[i].port, 1, tv[i].wr, tv[i].addr, tv[i].data);
            wait_took(!tv[i].port, tv[i].port);
            if (i == 0) begin
                wait_cycles(1);
                chk("busy_ic_ready", ic.req_ready, 0);
                chk("busy_dc_ready", dc.req_ready, 0);
            end
        end
        wait_cycles(LAT + 3);
        check_drained("txn");

        // Ties: both requesters valid from IDLE, four times in a row.
        rst_aL = 1'b0;
        wait_cycles(2);
        rst_aL = 1'b1;
        grant_log.delete();
        acc_cyc.delete();
        for (int k = 0; k < 4; k++) begin
            set_req(0, 1, 0, 16'd5, '0);
            set_req(1, 1, 0, 16'd3, '0);
            wait_took(1, 1);
        end
        wait_cycles(LAT + 3);
        check_drained("tie");
        chk("tie_grant_count", 64'(grant_log.size()), 64'd8);
        if (grant_log.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
`ifdef MEM_CTRL_ICACHE_PRIO_EN
                chk($sformatf("tie_grant%0d", i), grant_log[i], (i % 2 == 0) ? 1'b0 : 1'b1);
`else
                chk($sformatf("tie_grant%0d", i), grant_log[i], (i % 2 == 0) ? 1'b1 : 1'b0);
`endif
            end
            for (int k = 0; k < 4; k++)
                chk($sformatf("tie_loser_gap%0d", k), 64'(acc_cyc[2*k+1] - acc_cyc[2*k]), 64'(LAT + 1));
        end

        // Reset during a write's BUSY: the write stays committed.
        set_req(1, 1, 1, 16'd9, d_dat);
        wait_took(0, 1);
        wait_cycles(3);
        rst_aL = 1'b0;
        wait_cycles(2);
        rst_aL = 1'b1;

        // Reset during a read's BUSY: no response may ever appear for it.
        set_req(1, 1, 0, 16'd9, '0);
        wait_took(0, 1);
        wait_cycles(4);
        rst_aL = 1'b0;
        dc_q.delete();
        #1;
        chk("rst_busy_dc_resp_valid", dc.resp_valid, 0);
        wait_cycles(2);
        rst_aL = 1'b1;
        #1;
        chk("post_rst_ic_ready", ic.req_ready, 1);
        chk("post_rst_dc_ready", dc.req_ready, 1);
        wait_cycles(LAT + 3);
        set_req(1, 1, 0, 16'd9, '0);
        wait_took(0, 1);
        wait_cycles(LAT + 3);
        check_drained("rst");

        // MEM_LATENCY=1 instance: accept at T, response at T+1, next accept at T+2.
        dc1.req_valid = 1; dc1.req_type = 1; dc1.req_block_addr = 16'(NB1 + 2); dc1.req_block_data = e_dat;
        @(negedge clk);
        chk("l1_wr_ready", dc1.req_ready, 1);
        @(posedge clk); #1;
        dc1.req_valid = 0;
        @(negedge clk);
        chk("l1_wr_busy_ready", dc1.req_ready, 0);
        chk("l1_wr_no_resp", dc1.resp_valid, 0);
        @(posedge clk); #1;
        dc1.req_valid = 1; dc1.req_type = 0; dc1.req_block_addr = 16'd2;
        @(negedge clk);
        chk("l1_rd_ready_T", dc1.req_ready, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("l1_resp_valid_T1", dc1.resp_valid, 1);
        chk("l1_resp_data_T1", dc1.resp_block_data, e_dat);
        chk("l1_ready_T1", dc1.req_ready, 0);
        chk("l1_ic_no_resp", ic1.resp_valid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("l1_ready_T2", dc1.req_ready, 1);
        chk("l1_no_resp_T2", dc1.resp_valid, 0);
        @(posedge clk); #1;
        dc1.req_valid = 0;
        @(negedge clk);
        chk("l1_resp2_valid", dc1.resp_valid, 1);
        chk("l1_resp2_data", dc1.resp_block_data, e_dat);
        @(posedge clk); #1;
        @(negedge clk);
        chk("l1_resp2_single", dc1.resp_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
